periph_bus: RTL
===============

PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; reset is asserted while reset==0.
REQ-003 SHALL have port rd, input, 1 bit: read strobe from the CPU data path.
REQ-004 SHALL have port wr, input, 1 bit: peripheral write strobe, asserted by the CPU only when addr[30]==1.
REQ-005 SHALL have port addr, input, 32 bits: byte address; the ALU result.
REQ-006 SHALL have port wdata, input, 32 bits: write data, the Rt register value.
REQ-007 SHALL have port rdata, output, 32 bits: read data returned to the CPU.
REQ-008 SHALL have port led, output, 8 bits: LED drive.
REQ-009 SHALL have port switch, input, 8 bits: asynchronous board switches.
REQ-010 SHALL have port digi, output, 12 bits: 7-segment drive; [11:8] anode select, [7:0] segments.
REQ-011 SHALL have port irqout, output, 1 bit: timer interrupt request to the CPU IRQ input.

Function
REQ-012 SHALL decode the register map on addr[31:2], ignoring addr[1:0]: 0x40000000 TH, 0x40000004 TL, 0x40000008 TCON[2:0], 0x4000000C LED[7:0], 0x40000010 SWITCH[7:0] (read-only), 0x40000014 DIGI[11:0].
REQ-013 SHALL make rdata combinational: when rd==1 and the address is mapped, return the register zero-extended to 32 bits; otherwise return 0.
REQ-014 SHALL perform a write at the clock edge when wr==1 and the address is mapped, storing the low register-width bits of wdata.
REQ-015 SHALL ignore writes to SWITCH and to unmapped addresses, with no state change.
REQ-016 SHALL define the TCON bits as follows: bit0 is the timer enable, bit1 is the interrupt enable, and bit2 is the interrupt status.
REQ-017 SHALL increment TL by 1 on each cycle with TCON[0]==1 and TL!=0xFFFFFFFF.
REQ-018 SHALL, on a cycle with TCON[0]==1 and TL==0xFFFFFFFF (overflow), load TL<=TH and, when TCON[1]==1, set TCON[2]<=1.
REQ-019 SHALL hold TL unchanged while TCON[0]==0.
REQ-020 SHALL keep TCON[2] set until software writes TCON; the written wdata[2] value then replaces it.
REQ-021 SHALL drive irqout as a registered copy of TCON[2]; no extra cycle is added.
REQ-022 SHALL resolve a CPU write to TL in the same cycle as an increment or overflow so that the written value wins.
REQ-023 SHALL resolve a CPU write to TCON in the same cycle as an overflow so that all written bits win, and the status is not set that cycle.
REQ-024 SHALL resolve a CPU write to TH in the same cycle as an overflow so that the reload uses the pre-write TH value.
REQ-025 SHALL pass switch through a two-flop synchronizer; a SWITCH read returns the second stage, so a switch change is visible 2 edges later.
REQ-026 SHALL drive led and digi directly from the LED and DIGI registers.
REQ-027 SHALL treat rd and wr asserted together as independent: the read returns the pre-write value.

Reset
REQ-028 SHALL, while reset==0, asynchronously clear TH, TL, TCON, LED, DIGI and both synchronizer stages to 0.
REQ-029 SHALL hold led=0, digi=0 and irqout=0 during reset and for the first cycle after release.
REQ-030 SHALL resume counting only after software sets TCON[0]; reset asserted mid-count SHALL abort the count and clear any pending interrupt.

Verification
REQ-031 SHALL verify the directed scenario: write TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL sequence FFFFFFFF, FFFFFFFD, FFFFFFFE, FFFFFFFF, FFFFFFFD; irqout=1 after the first overflow edge.
REQ-032 SHALL verify the directed scenario: with irqout=1, write TCON=3 -> irqout=0 on the next cycle and the count continues.
REQ-033 SHALL verify the directed scenario: TL=0xFFFFFFFF, TCON=3, with a TL write of 0x10 at the overflow edge -> TL=0x10 and irqout still set (TCON not written).
REQ-034 SHALL verify the directed scenario: write LED=0x1A5 and DIGI=0xFFF3A -> led=0xA5, digi=0xF3A; a read of 0x4000000C returns 0x000000A5; a write to 0x40000018 changes nothing.
REQ-035 SHALL verify the directed scenario: switch changes 0x00 to 0x5C -> reading 0x40000010 returns 0x00 for 1 edge and 0x5C from the 2nd edge; with rd=0, rdata=0.
REQ-036 SHALL verify the directed scenario: counting with TCON=3 and TL=0x1234, pulse reset low between edges -> all outputs and registers are 0 immediately; TL stays 0 after release until TCON is written.

Source files
------------

// File: rtl/periph_bus.sv
// Memory-mapped peripheral block: reload timer with interrupt, LED and
// 7-segment registers, and a synchronized switch input.
module periph_bus (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  input  logic [7:0]  switch,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam logic [29:0] A_TH   = 30'h1000_0000;
  localparam logic [29:0] A_TL   = 30'h1000_0001;
  localparam logic [29:0] A_TCON = 30'h1000_0002;
  localparam logic [29:0] A_LED  = 30'h1000_0003;
  localparam logic [29:0] A_SW   = 30'h1000_0004;
  localparam logic [29:0] A_DIGI = 30'h1000_0005;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [7:0]  sw1_q, sw2_q;

  logic [29:0] word;
  logic        sel_th, sel_tl, sel_tcon;
  logic        sel_led, sel_sw, sel_digi;
  logic        ovf;
  logic        unused_addr;

  assign word        = addr[31:2];
  assign unused_addr = ^addr[1:0];

  assign sel_th   = (word == A_TH);
  assign sel_tl   = (word == A_TL);
  assign sel_tcon = (word == A_TCON);
  assign sel_led  = (word == A_LED);
  assign sel_sw   = (word == A_SW);
  assign sel_digi = (word == A_DIGI);

  assign ovf = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  // CPU writes are applied last so they override timer activity
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
    if (wr) begin
      if (sel_th)   th_d   = wdata;
      if (sel_tl)   tl_d   = wdata;
      if (sel_tcon) tcon_d = wdata[2:0];
      if (sel_led)  led_d  = wdata[7:0];
      if (sel_digi) digi_d = wdata[11:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      sw1_q  <= '0;
      sw2_q  <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      sw1_q  <= switch;
      sw2_q  <= sw1_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        sel_th:   rdata = th_q;
        sel_tl:   rdata = tl_q;
        sel_tcon: rdata = {29'd0, tcon_q};
        sel_led:  rdata = {24'd0, led_q};
        sel_sw:   rdata = {24'd0, sw2_q};
        sel_digi: rdata = {20'd0, digi_q};
        default:  rdata = '0;
      endcase
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2];

endmodule
